// File: rtl/mips_multicycle_core_if.sv
// Instruction and data memory request/valid buses of the multi-cycle MIPS core.
// Each req holds until its rvalid pulse; address, data, we and be stay frozen while req is high.
interface mips_multicycle_core_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_rvalid, inst_rdata,
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_rvalid, data_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_rvalid, inst_rdata,
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_rvalid, data_rdata
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 subset core: FETCH/DECODE/EXEC/MEM/WB over handshaked memories,
// with a commit-trace port and a sticky fault halt.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter bit          TRACE_EN    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    mips_multicycle_core_if.master        bus,
    output logic                          wb_en,
    output logic [31:0]                   wb_pc,
    output logic [4:0]                    wb_reg,
    output logic [31:0]                   wb_data,
    output logic                          fault,
    output logic [1:0]                    fault_cause
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LB = 6'h20, OP_LW = 6'h23, OP_LBU = 6'h24, OP_SB = 6'h28, OP_SW = 6'h2B;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0] res_q, res_d, npc_q, npc_d, wait_cnt_q, wait_cnt_d;
    logic [4:0]  dst_q, dst_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] rf_q [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] pc_plus4, ea;
    logic [7:0]  lane_byte;
    logic        timed_out, is_store;

    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign shamt     = ir_q[10:6];
    assign funct     = ir_q[5:0];
    assign pc_plus4  = pc_q + 32'd4;
    assign ea        = a_q + imm_q;
    assign lane_byte = bus.data_rdata[{res_q[1:0], 3'b000} +: 8];
    assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt_q == MEM_TIMEOUT);
    assign is_store  = (op == OP_SW) || (op == OP_SB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            res_q      <= '0;
            npc_q      <= '0;
            wait_cnt_q <= '0;
            dst_q      <= '0;
            fault_q    <= 1'b0;
            cause_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            res_q      <= res_d;
            npc_q      <= npc_d;
            wait_cnt_q <= wait_cnt_d;
            dst_q      <= dst_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
        end
    end

    // r0 is never written, so reading it always yields zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (state_q == S_WB && dst_q != 5'd0) begin
            rf_q[dst_q] <= res_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        res_d      = res_q;
        npc_d      = npc_q;
        dst_d      = dst_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        wait_cnt_d = '0;
        case (state_q)
            S_FETCH: begin
                if (bus.inst_rvalid) begin
                    ir_d    = bus.inst_rdata;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    fault_d = 1'b1;
                    cause_d = 2'd2;
                    state_d = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs];
                b_d     = rf_q[rt];
                imm_d   = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ?
                          {16'h0, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = '0;
                dst_d   = rt;
                npc_d   = pc_plus4;
                state_d = S_WB;
                case (op)
                    OP_RTYPE: begin
                        dst_d = rd;
                        case (funct)
                            6'h00: res_d = b_q << shamt;
                            6'h02: res_d = b_q >> shamt;
                            6'h03: res_d = $unsigned($signed(b_q) >>> shamt);
                            6'h04: res_d = b_q << a_q[4:0];
                            6'h06: res_d = b_q >> a_q[4:0];
                            6'h07: res_d = $unsigned($signed(b_q) >>> a_q[4:0]);
                            6'h08: begin
                                dst_d = 5'd0;
                                npc_d = a_q;
                            end
                            6'h21: res_d = a_q + b_q;
                            6'h23: res_d = a_q - b_q;
                            6'h24: res_d = a_q & b_q;
                            6'h25: res_d = a_q | b_q;
                            6'h26: res_d = a_q ^ b_q;
                            6'h27: res_d = ~(a_q | b_q);
                            6'h2A: res_d = {31'd0, $signed(a_q) < $signed(b_q)};
                            6'h2B: res_d = {31'd0, a_q < b_q};
                            default: begin
                                fault_d = 1'b1;
                                cause_d = 2'd0;
                                state_d = S_HALT;
                            end
                        endcase
                    end
                    OP_ADDIU: res_d = a_q + imm_q;
                    OP_SLTI:  res_d = {31'd0, $signed(a_q) < $signed(imm_q)};
                    OP_SLTIU: res_d = {31'd0, a_q < imm_q};
                    OP_ANDI:  res_d = a_q & imm_q;
                    OP_ORI:   res_d = a_q | imm_q;
                    OP_XORI:  res_d = a_q ^ imm_q;
                    OP_LUI:   res_d = {ir_q[15:0], 16'h0};
                    OP_BEQ, OP_BNE: begin
                        dst_d = 5'd0;
                        if ((a_q == b_q) == (op == OP_BEQ)) npc_d = pc_plus4 + {imm_q[29:0], 2'b00};
                    end
                    OP_J, OP_JAL: begin
                        dst_d = (op == OP_JAL) ? 5'd31 : 5'd0;
                        res_d = (op == OP_JAL) ? pc_plus4 : 32'd0;
                        npc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                    end
                    OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: begin
                        res_d   = ea;
                        dst_d   = is_store ? 5'd0 : rt;
                        state_d = S_MEM;
                        // Word accesses fault before any request reaches the bus.
                        if ((op == OP_LW || op == OP_SW) && ea[1:0] != 2'b00) begin
                            fault_d = 1'b1;
                            cause_d = 2'd1;
                            state_d = S_HALT;
                        end
                    end
                    default: begin
                        fault_d = 1'b1;
                        cause_d = 2'd0;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                if (bus.data_rvalid) begin
                    if (op == OP_LW) res_d = bus.data_rdata;
                    else if (op == OP_LB) res_d = {{24{lane_byte[7]}}, lane_byte};
                    else if (op == OP_LBU) res_d = {24'h0, lane_byte};
                    state_d = S_WB;
                end else if (timed_out) begin
                    fault_d = 1'b1;
                    cause_d = 2'd2;
                    state_d = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            S_WB: begin
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Bus and trace outputs are forced low while rst is held.
    always_comb begin
        bus.inst_req   = !rst && state_q == S_FETCH;
        bus.inst_addr  = bus.inst_req ? pc_q : 32'd0;
        bus.data_req   = !rst && state_q == S_MEM;
        bus.data_we    = bus.data_req && is_store;
        bus.data_be    = 4'b0000;
        bus.data_addr  = bus.data_req ? {res_q[31:2], 2'b00} : 32'd0;
        bus.data_wdata = 32'd0;
        if (bus.data_req) begin
            bus.data_be = (op == OP_SB) ? (4'b0001 << res_q[1:0]) : 4'b1111;
            if (op == OP_SB) bus.data_wdata = {4{b_q[7:0]}};
            else if (op == OP_SW) bus.data_wdata = b_q;
        end
        wb_en       = TRACE_EN && !rst && state_q == S_WB;
        wb_pc       = wb_en ? pc_q : 32'd0;
        wb_reg      = wb_en ? dst_q : 5'd0;
        wb_data     = (wb_en && dst_q != 5'd0) ? res_q : 32'd0;
        fault       = fault_q;
        fault_cause = cause_q;
    end
endmodule
